rps_match_ctrl: RTL and testbench

Match controller for the stone-paper-scissors game. Collects one move per player per round over valid/ready handshakes, enforces a per-round move timeout (forfeit), judges each round, keeps scores and ends the match when a player reaches WIN_TARGET round wins. Sits between the player input logic and the display/output mapping. The output mapping consumes round_result and match_winner.

---
 rtl/rps_pkg.sv | 29 ++
 rtl/rps_match_ctrl_if.sv | 22 ++
 rtl/rps_judge.sv | 25 ++
 rtl/rps_match_ctrl.sv | 154 +++++++++++++++
 tb/tb_rps_match_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rps_pkg.sv
// Shared move, result and state encodings for the stone-paper-scissors match controller.
package rps_pkg;

    localparam int unsigned MOVE_W = 2;
    localparam int unsigned RES_W  = 2;

    typedef enum logic [MOVE_W-1:0] {
        MV_STONE    = 2'b00,
        MV_PAPER    = 2'b01,
        MV_SCISSORS = 2'b10,
        MV_INVALID  = 2'b11
    } move_e;

    typedef enum logic [RES_W-1:0] {
        RES_TIE     = 2'b00,
        RES_P1      = 2'b01,
        RES_P2      = 2'b10,
        RES_INVALID = 2'b11
    } res_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        JUDGE   = 3'd2,
        REPORT  = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/rps_match_ctrl_if.sv
// Player move handshakes: players drive valid/move, the controller drives ready.
interface rps_match_ctrl_if;
    import rps_pkg::*;

    logic              p1_valid;
    logic [MOVE_W-1:0] p1_move;
    logic              p1_ready;
    logic              p2_valid;
    logic [MOVE_W-1:0] p2_move;
    logic              p2_ready;

    modport master (
        output p1_valid, p1_move, p2_valid, p2_move,
        input  p1_ready, p2_ready
    );

    modport slave (
        input  p1_valid, p1_move, p2_valid, p2_move,
        output p1_ready, p2_ready
    );

endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: two moves in, tie / P1 / P2 / invalid out.
module rps_judge
    import rps_pkg::*;
(
    input  move_e p1_move,
    input  move_e p2_move,
    output res_e  result
);

    always_comb begin
        result = RES_TIE;
        if (p1_move == MV_INVALID || p2_move == MV_INVALID) begin
            result = RES_INVALID;
        end else if (p1_move == p2_move) begin
            result = RES_TIE;
        end else if ((p1_move == MV_PAPER    && p2_move == MV_STONE)    ||
                     (p1_move == MV_STONE    && p2_move == MV_SCISSORS) ||
                     (p1_move == MV_SCISSORS && p2_move == MV_PAPER)) begin
            result = RES_P1;
        end else begin
            result = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: collects one move per player per round, handles timeout forfeits,
// judges rounds, keeps scores and ends the match at WIN_TARGET round wins.
module rps_match_ctrl
    import rps_pkg::*;
#(
    parameter int unsigned WIN_TARGET  = 2,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    rps_match_ctrl_if.slave    plr,
    output logic               round_valid,
    output logic [RES_W-1:0]   round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               busy,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam int unsigned        TMR_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_TARGET);

    state_e           state;
    logic [TMR_W-1:0] timer;
    logic             cap1;
    logic             cap2;
    move_e            mv1;
    move_e            mv2;
    logic             p1_ready_q;
    logic             p2_ready_q;
    res_e             judge_res_c;

    logic take1_c;
    logic take2_c;
    logic got1_c;
    logic got2_c;

    // A capture in the current cycle counts toward "both moves in" on the same edge.
    assign take1_c = plr.p1_valid & p1_ready_q;
    assign take2_c = plr.p2_valid & p2_ready_q;
    assign got1_c  = cap1 | take1_c;
    assign got2_c  = cap2 | take2_c;

    assign plr.p1_ready = p1_ready_q;
    assign plr.p2_ready = p2_ready_q;

    rps_judge u_judge (
        .p1_move (mv1),
        .p2_move (mv2),
        .result  (judge_res_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            cap1         <= 1'b0;
            cap2         <= 1'b0;
            mv1          <= MV_STONE;
            mv2          <= MV_STONE;
            p1_ready_q   <= 1'b0;
            p2_ready_q   <= 1'b0;
            round_valid  <= 1'b0;
            round_result <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            busy         <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= COLLECT;
                        timer        <= '0;
                        cap1         <= 1'b0;
                        cap2         <= 1'b0;
                        p1_ready_q   <= 1'b1;
                        p2_ready_q   <= 1'b1;
                        round_result <= '0;
                        p1_score     <= '0;
                        p2_score     <= '0;
                        busy         <= 1'b1;
                        match_done   <= 1'b0;
                        match_winner <= '0;
                    end
                end

                COLLECT: begin
                    if (take1_c) begin
                        mv1  <= move_e'(plr.p1_move);
                        cap1 <= 1'b1;
                    end
                    if (take2_c) begin
                        mv2  <= move_e'(plr.p2_move);
                        cap2 <= 1'b1;
                    end
                    if ((got1_c && got2_c) || timer == TMR_LAST) begin
                        state      <= JUDGE;
                        p1_ready_q <= 1'b0;
                        p2_ready_q <= 1'b0;
                    end else begin
                        timer      <= timer + 1'b1;
                        p1_ready_q <= ~got1_c;
                        p2_ready_q <= ~got2_c;
                    end
                end

                // Forfeit outranks an invalid move; an invalid round leaves scores alone.
                JUDGE: begin
                    state       <= REPORT;
                    round_valid <= 1'b1;
                    if (cap1 && !cap2) begin
                        round_result <= RES_P1;
                        p1_score     <= p1_score + 1'b1;
                    end else if (!cap1 && cap2) begin
                        round_result <= RES_P2;
                        p2_score     <= p2_score + 1'b1;
                    end else if (!cap1 && !cap2) begin
                        round_result <= RES_TIE;
                    end else begin
                        round_result <= judge_res_c;
                        if (judge_res_c == RES_P1) p1_score <= p1_score + 1'b1;
                        if (judge_res_c == RES_P2) p2_score <= p2_score + 1'b1;
                    end
                end

                REPORT: begin
                    round_valid <= 1'b0;
                    if (p1_score == SCORE_WIN || p2_score == SCORE_WIN) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        match_done   <= 1'b1;
                        match_winner <= (p1_score == SCORE_WIN) ? 2'b01 : 2'b10;
                    end else begin
                        state      <= COLLECT;
                        timer      <= '0;
                        cap1       <= 1'b0;
                        cap2       <= 1'b0;
                        p1_ready_q <= 1'b1;
                        p2_ready_q <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Scoreboard bench for rps_match_ctrl: stimulus pushes expected rounds, a monitor pops and checks.
module tb_rps_match_ctrl;

    typedef struct {
        logic [1:0] res;
        logic [3:0] s1;
        logic [3:0] s2;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       round_valid;
    logic [1:0] round_result;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       busy;
    logic       match_done;
    logic [1:0] match_winner;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   c0;
    exp_t sb[$];

    rps_match_ctrl_if plr ();

    rps_match_ctrl #(
        .WIN_TARGET  (2),
        .TIMEOUT_CYC (8),
        .SCORE_W     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .plr          (plr),
        .round_valid  (round_valid),
        .round_result (round_result),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .busy         (busy),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // All stimulus moves at negedge+1 so the monitor (at negedge) always runs first.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] res, input int s1, input int s2, input int at);
        exp_t e;
        e.res = res;
        e.s1  = 4'(s1);
        e.s2  = 4'(s2);
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && round_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_round_valid", 0, 1);
                end else begin
                    e = sb.pop_front();
                    chk("round_result", int'(round_result), int'(e.res));
                    chk("p1_score", int'(p1_score), int'(e.s1));
                    chk("p2_score", int'(p2_score), int'(e.s2));
                    if (e.cyc >= 0) chk("round_latency", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic submit(input logic [1:0] m1, input logic [1:0] m2,
                          input logic [1:0] res, input int s1, input int s2);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (plr.p1_ready && plr.p2_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("both_ready_wait", int'(ok), 1);
        plr.p1_valid = 1'b1;
        plr.p1_move  = m1;
        plr.p2_valid = 1'b1;
        plr.p2_move  = m2;
        push(res, s1, s2, cyc + 2);
        step();
        plr.p1_valid = 1'b0;
        plr.p2_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("round_report_wait", int'(ok), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_done(input int winner);
        chk("match_done", int'(match_done), 1);
        chk("match_winner", int'(match_winner), winner);
        chk("busy_in_done", int'(busy), 0);
        chk("p1_ready_in_done", int'(plr.p1_ready), 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_p1_score"}, int'(p1_score), 0);
        chk({tag, "_p2_score"}, int'(p2_score), 0);
        chk({tag, "_round_result"}, int'(round_result), 0);
        chk({tag, "_match_winner"}, int'(match_winner), 0);
        chk({tag, "_match_done"}, int'(match_done), 0);
    endtask

    initial begin
        plr.p1_valid = 1'b0;
        plr.p1_move  = 2'b00;
        plr.p2_valid = 1'b0;
        plr.p2_move  = 2'b00;
        fork
            monitor();
        join_none

        repeat (3) step();
        chk("rst_p1_ready", int'(plr.p1_ready), 0);
        chk("rst_p2_ready", int'(plr.p2_ready), 0);
        chk("rst_round_valid", int'(round_valid), 0);
        chk("rst_busy", int'(busy), 0);
        check_cleared("rst");
        rst = 1'b0;
        step();

        // Match 1: paper beats stone twice, P1 takes the match.
        pulse_start();
        chk("start_busy", int'(busy), 1);
        chk("start_p1_ready", int'(plr.p1_ready), 1);
        chk("start_p2_ready", int'(plr.p2_ready), 1);
        submit(2'b01, 2'b00, 2'b01, 1, 0);
        drain();
        submit(2'b01, 2'b00, 2'b01, 2, 0);
        drain();
        step();
        check_done(1);

        // Match 2 from DONE: scores and winner cleared.
        pulse_start();
        check_cleared("restart");
        chk("restart_busy", int'(busy), 1);
        submit(2'b10, 2'b10, 2'b00, 0, 0);
        drain();
        step();
        chk("tie_p1_ready", int'(plr.p1_ready), 1);
        chk("tie_p2_ready", int'(plr.p2_ready), 1);
        submit(2'b11, 2'b00, 2'b11, 0, 0);
        drain();

        // Only P2 submits, in cycle 3: forfeit to P2 after 8 COLLECT cycles.
        step();
        c0 = cyc;
        repeat (3) step();
        plr.p2_valid = 1'b1;
        plr.p2_move  = 2'b00;
        push(2'b10, 0, 1, c0 + 9);
        step();
        plr.p2_valid = 1'b0;
        drain();

        // Nobody submits: tie on timeout.
        step();
        c0 = cyc;
        push(2'b00, 0, 1, c0 + 9);
        drain();

        // P1 scissors early, second P1 offer ignored, P2 paper in the last cycle.
        step();
        c0 = cyc;
        plr.p1_valid = 1'b1;
        plr.p1_move  = 2'b10;
        push(2'b01, 1, 1, c0 + 9);
        step();
        plr.p1_valid = 1'b0;
        chk("after_cap_p1_ready", int'(plr.p1_ready), 0);
        chk("after_cap_p2_ready", int'(plr.p2_ready), 1);
        step();
        plr.p1_valid = 1'b1;
        plr.p1_move  = 2'b00;
        step();
        plr.p1_valid = 1'b0;
        repeat (4) step();
        plr.p2_valid = 1'b1;
        plr.p2_move  = 2'b01;
        step();
        plr.p2_valid = 1'b0;
        drain();

        // start ignored mid-COLLECT, then reset mid-COLLECT.
        step();
        pulse_start();
        chk("midstart_busy", int'(busy), 1);
        chk("midstart_p1_score", int'(p1_score), 1);
        chk("midstart_p1_ready", int'(plr.p1_ready), 1);
        rst = 1'b1;
        step();
        chk("midrst_p1_ready", int'(plr.p1_ready), 0);
        chk("midrst_p2_ready", int'(plr.p2_ready), 0);
        chk("midrst_round_valid", int'(round_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        check_cleared("midrst");
        rst = 1'b0;
        step();

        // Match 3: stone beats scissors, then P2 wins twice.
        pulse_start();
        submit(2'b00, 2'b10, 2'b01, 1, 0);
        drain();
        submit(2'b00, 2'b01, 2'b10, 1, 1);
        drain();
        submit(2'b10, 2'b00, 2'b10, 1, 2);
        drain();
        step();
        check_done(2);

        repeat (4) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
